cmos_pattern_gen: RTL and testbench

- Parametrised camera-stream source. Successor to the fixed bitmap-fed CMOS model.
- Produces vsync/href/clken/data with configurable blanking, clken decimation, channel count and channel width.
- Provides four built-in test patterns, so the haze-removal pipeline can be driven and checked without a BMP file.
- Synthesizable. Also used as the stimulus source in unit benches.

---
 rtl/cmos_pattern_gen.sv | 110 +++++++++++
 tb/tb_cmos_pattern_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_pattern_gen.sv
// cmos_pattern_gen: parametrised camera-stream source with blanking, clken decimation and four test patterns
module cmos_pattern_gen #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_BLANK   = 160,
    parameter int VS_LINES  = 2,
    parameter int VB_LINES  = 8,
    parameter int VF_LINES  = 4,
    parameter int CLKEN_DIV = 1,
    parameter int CH_NUM    = 3,
    parameter int CH_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    output logic                       gen_vsync,
    output logic                       gen_href,
    output logic                       gen_clken,
    output logic [CH_NUM*CH_WIDTH-1:0] gen_data,
    output logic [15:0]                x_pos,
    output logic [15:0]                y_pos,
    output logic [15:0]                frame_cnt
);
    localparam int LINE_CYC = IMG_HDISP * CLKEN_DIV + H_BLANK;
    localparam int CW       = $clog2(LINE_CYC + 1);
    localparam int DIVW     = $clog2(CLKEN_DIV + 1);
    localparam int DW       = CH_NUM * CH_WIDTH;

    typedef enum logic [2:0] {IDLE, VSYNC, VBLANK, ACTIVE, VFRONT} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cyc, cyc_n;
    logic [15:0]     line, line_n, lim;
    logic [DIVW-1:0] dcnt, dcnt_n;
    logic [1:0]      mode_q;
    logic            line_end, last_line, frame_done, href_n, clken_n;
    logic [15:0]     x_n, y_n;
    logic [2:0]      bar;
    logic [DW-1:0]   data_n;

    // next-state, line/cycle counters and the registered-output precursors
    always_comb begin
        line_end   = cyc == CW'(LINE_CYC - 1);
        lim        = state == VSYNC  ? 16'(VS_LINES)  :
                     state == VBLANK ? 16'(VB_LINES)  :
                     state == ACTIVE ? 16'(IMG_VDISP) : 16'(VF_LINES);
        last_line  = line_end && line == lim - 16'd1;
        frame_done = state == VFRONT && last_line;
        state_n    = state == IDLE   ? (enable ? VSYNC : IDLE) :
                     !last_line      ? state :
                     state == VSYNC  ? (VB_LINES == 0 ? ACTIVE : VBLANK) :
                     state == VBLANK ? ACTIVE :
                     state == ACTIVE ? VFRONT : (enable ? VSYNC : IDLE);
        cyc_n      = (state == IDLE || line_end) ? '0 : cyc + CW'(1);
        line_n     = (state == IDLE || last_line) ? '0 : line_end ? line + 16'd1 : line;
        dcnt_n     = (cyc_n == '0 || dcnt == DIVW'(CLKEN_DIV - 1)) ? '0 : dcnt + DIVW'(1);
        href_n     = state_n == ACTIVE && cyc_n < CW'(IMG_HDISP * CLKEN_DIV);
        clken_n    = href_n && dcnt_n == '0;
        x_n        = cyc_n == '0 ? '0 : x_pos + 16'd1;
        y_n        = line_n;
        bar        = 3'((32'(x_n) * 8) / IMG_HDISP);
    end

    // colour bars drive only the first three channels; the rest stay dark
    for (genvar g = 0; g < CH_NUM; g++) begin : ch
        assign data_n[g*CH_WIDTH +: CH_WIDTH] =
            mode_q == 2'd0 ? CH_WIDTH'(x_n) :
            mode_q == 2'd1 ? CH_WIDTH'(y_n) :
            mode_q == 2'd2 ? {CH_WIDTH{(g < 3) && bar[g % 3]}} : CH_WIDTH'(frame_cnt);
    end

    // state, counters and all outputs registered together so they stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cyc       <= '0;
            line      <= '0;
            dcnt      <= '0;
            mode_q    <= '0;
            frame_cnt <= '0;
            gen_vsync <= 1'b0;
            gen_href  <= 1'b0;
            gen_clken <= 1'b0;
            gen_data  <= '0;
            x_pos     <= '0;
            y_pos     <= '0;
        end else begin
            state     <= state_n;
            cyc       <= cyc_n;
            line      <= line_n;
            dcnt      <= dcnt_n;
            if (state == VSYNC && line == '0 && cyc == '0)
                mode_q <= mode;
            if (frame_done)
                frame_cnt <= frame_cnt + 16'd1;
            gen_vsync <= state_n == VSYNC;
            gen_href  <= href_n;
            gen_clken <= clken_n;
            gen_data  <= clken_n ? data_n : '0;
            if (state_n == IDLE || (state_n == VSYNC && state != VSYNC)) begin
                x_pos <= '0;
                y_pos <= '0;
            end else if (clken_n) begin
                x_pos <= x_n;
                y_pos <= y_n;
            end
        end
    end
endmodule

// File: tb/tb_cmos_pattern_gen.sv
// tb_cmos_pattern_gen: vector table, directed corner sequences and a frame-time reference model
module tb_cmos_pattern_gen;
    localparam int HD = 4, VD = 3, HB = 2, VS = 1, VB = 1, VF = 1, DV = 1;
    localparam int LC = HD * DV + HB;
    localparam int FRAME = (VS + VB + VD + VF) * LC;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic [1:0] mode = 2'd0;
    always #5 clk = ~clk;

    logic vs, hr, ck, b_vs, b_hr, b_ck, d_vs, d_hr, d_ck;
    logic [23:0] dat, b_dat, d_dat;
    logic [15:0] xp, yp, fc, b_xp, b_yp, b_fc, d_xp, d_yp, d_fc;

    cmos_pattern_gen #(.IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB), .VS_LINES(VS), .VB_LINES(VB),
        .VF_LINES(VF), .CLKEN_DIV(DV), .CH_NUM(3), .CH_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .gen_vsync(vs), .gen_href(hr),
        .gen_clken(ck), .gen_data(dat), .x_pos(xp), .y_pos(yp), .frame_cnt(fc));
    cmos_pattern_gen #(.IMG_HDISP(8), .IMG_VDISP(VD), .H_BLANK(HB), .VS_LINES(VS), .VB_LINES(VB),
        .VF_LINES(VF), .CLKEN_DIV(1), .CH_NUM(3), .CH_WIDTH(8)) dut_bar (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .gen_vsync(b_vs), .gen_href(b_hr),
        .gen_clken(b_ck), .gen_data(b_dat), .x_pos(b_xp), .y_pos(b_yp), .frame_cnt(b_fc));
    cmos_pattern_gen #(.IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB), .VS_LINES(VS), .VB_LINES(VB),
        .VF_LINES(VF), .CLKEN_DIV(3), .CH_NUM(3), .CH_WIDTH(8)) dut_div (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .gen_vsync(d_vs), .gen_href(d_hr),
        .gen_clken(d_ck), .gen_data(d_dat), .x_pos(d_xp), .y_pos(d_yp), .frame_cnt(d_fc));

    int vectors = 0, miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // reference model: position inside the frame derived from elapsed cycles
    typedef struct {
        bit run; int t; int fc; int md;
        logic vs, hr, ck; logic [23:0] d; logic [15:0] x, y;
    } mdl_t;
    mdl_t ms;

    function automatic logic [23:0] bars(input logic [15:0] x);
        int b = int'(x) * 8 / HD;
        return {(b & 4) != 0 ? 8'hFF : 8'h00, (b & 2) != 0 ? 8'hFF : 8'h00, (b & 1) != 0 ? 8'hFF : 8'h00};
    endfunction

    function automatic mdl_t step(input mdl_t s, input logic en, input logic [1:0] m);
        mdl_t n = s;
        int l, c, al;
        if (s.run && s.t == 0) n.md = int'(m);
        if (!s.run) begin
            n.run = en; n.t = 0;
        end else if (s.t == FRAME - 1) begin
            n.fc = (s.fc + 1) & 16'hFFFF; n.run = en; n.t = 0;
        end else n.t = s.t + 1;
        if (!n.run || n.t == 0) begin
            n.x = 0; n.y = 0;
        end
        l = n.t / LC; c = n.t % LC; al = l - VS - VB;
        n.vs = n.run && l < VS;
        n.hr = n.run && al >= 0 && al < VD && c < HD * DV;
        n.ck = n.hr && (c % DV) == 0;
        if (n.ck) begin
            n.x = 16'(c / DV); n.y = 16'(al);
        end
        n.d = !n.ck ? 24'h0 : n.md == 0 ? {3{n.x[7:0]}} : n.md == 1 ? {3{n.y[7:0]}} :
              n.md == 2 ? bars(n.x) : {3{8'(n.fc)}};
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ms <= '{default: 0};
        else ms <= step(ms, enable, mode);
    end

    typedef struct {
        int md; int t; logic vs, hr, ck; logic [23:0] d; logic [15:0] x, y, f;
    } vec_t;
    vec_t tbl[16];

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start(input int m);
        mode = 2'(m); enable = 1'b1;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic chk_all(input string p, input logic v, h, c, input logic [23:0] d,
                           input logic [15:0] x, y, f);
        chk({p, "_vsync"}, vs, v); chk({p, "_href"}, hr, h); chk({p, "_clken"}, ck, c);
        chk({p, "_data"}, dat, d); chk({p, "_x"}, xp, x); chk({p, "_y"}, yp, y);
        chk({p, "_fcnt"}, fc, f);
    endtask

    initial begin
        int nv, nh, nw, nc, nb, nd;
        bit pr, seen, done;
        int h0;
        logic [23:0] q[8];
        int off[4];
        logic [15:0] xs[4];
        logic [23:0] bar_exp[8];
        bar_exp = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                    24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
        tbl = '{
            '{0,  0, 1, 0, 0, 24'h000000, 0, 0, 0},
            '{0,  5, 1, 0, 0, 24'h000000, 0, 0, 0},
            '{0,  6, 0, 0, 0, 24'h000000, 0, 0, 0},
            '{0, 12, 0, 1, 1, 24'h000000, 0, 0, 0},
            '{0, 13, 0, 1, 1, 24'h010101, 1, 0, 0},
            '{0, 15, 0, 1, 1, 24'h030303, 3, 0, 0},
            '{0, 16, 0, 0, 0, 24'h000000, 3, 0, 0},
            '{0, 20, 0, 1, 1, 24'h020202, 2, 1, 0},
            '{1, 19, 0, 1, 1, 24'h010101, 1, 1, 0},
            '{1, 27, 0, 1, 1, 24'h020202, 3, 2, 0},
            '{2, 13, 0, 1, 1, 24'h00FF00, 1, 0, 0},
            '{2, 15, 0, 1, 1, 24'hFFFF00, 3, 0, 0},
            '{0, 35, 0, 0, 0, 24'h000000, 3, 2, 0},
            '{0, 36, 1, 0, 0, 24'h000000, 0, 0, 1},
            '{3, 48, 0, 1, 1, 24'h010101, 0, 0, 1},
            '{3, 12, 0, 1, 1, 24'h000000, 0, 0, 0}};

        // reset state
        @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);

        // vector table
        foreach (tbl[i]) begin
            do_reset();
            start(tbl[i].md);
            repeat (tbl[i].t) @(negedge clk);
            chk_all($sformatf("tbl%0d", i), tbl[i].vs, tbl[i].hr, tbl[i].ck, tbl[i].d,
                    tbl[i].x, tbl[i].y, tbl[i].f);
        end

        // one-frame timing census
        do_reset();
        start(0);
        nv = 0; nh = 0; nw = 0; nc = 0; pr = 0;
        for (int i = 0; i < FRAME; i++) begin
            nv += int'(vs); nh += int'(hr); nw += int'(hr && !pr); pr = hr;
            if (ck) begin
                chk($sformatf("census_x%0d", nc), xp, 16'(nc % HD));
                nc++;
            end
            @(negedge clk);
        end
        chk("census_vsync_cycles", 64'(nv), 6);
        chk("census_href_cycles", 64'(nh), 12);
        chk("census_href_windows", 64'(nw), 3);
        chk("census_clken_pulses", 64'(nc), 12);
        chk("census_frame_cnt", fc, 1);
        chk("census_next_vsync", vs, 1);

        // colour bars on an 8-pixel line
        do_reset();
        start(2);
        nb = 0;
        q = '{default: 24'h0};
        for (int i = 0; i < 80 && nb < 8; i++) begin
            if (b_ck) begin q[nb] = b_dat; nb++; end
            @(negedge clk);
        end
        chk("bar_pixels", 64'(nb), 8);
        for (int k = 0; k < 8; k++) chk($sformatf("bar_px%0d", k), q[k], bar_exp[k]);

        // clken decimation by 3
        do_reset();
        start(0);
        seen = 0; done = 0; nh = 0; nd = 0; h0 = 0;
        off = '{default: -1};
        xs = '{default: 16'hFFFF};
        for (int i = 0; i < 100 && !done; i++) begin
            if (d_hr) begin
                if (!seen) begin seen = 1; h0 = i; end
                nh++;
                if (d_ck) begin
                    if (nd < 4) begin off[nd] = i - h0; xs[nd] = d_xp; end
                    nd++;
                end
            end else if (seen) done = 1;
            @(negedge clk);
        end
        chk("div_href_cycles", 64'(nh), 12);
        chk("div_clken_pulses", 64'(nd), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("div_off%0d", k), 64'(off[k]), 64'(3 * k));
            chk($sformatf("div_x%0d", k), xs[k], 16'(k));
        end

        // enable dropped mid-frame, mode change deferred
        do_reset();
        start(0);
        repeat (20) @(negedge clk);
        enable = 1'b0; mode = 2'd3;
        repeat (6) @(negedge clk);
        chk_all("drop_t26", 0, 1, 1, 24'h020202, 2, 2, 0);
        repeat (9) @(negedge clk);
        chk("drop_t35_fcnt", fc, 0);
        @(negedge clk);
        chk_all("drop_idle", 0, 0, 0, 0, 0, 0, 1);
        repeat (4) @(negedge clk);
        chk_all("drop_idle_hold", 0, 0, 0, 0, 0, 0, 1);
        start(3);
        chk("restart_vsync", vs, 1);
        repeat (12) @(negedge clk);
        chk_all("restart_flat", 0, 1, 1, 24'h010101, 0, 0, 1);

        // asynchronous reset mid-line
        do_reset();
        start(0);
        repeat (49) @(negedge clk);
        chk_all("prerst", 0, 1, 1, 24'h010101, 1, 0, 1);
        #2 rst_n = 1'b0;
        #1 chk_all("inrst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_all("postrst_t0", 1, 0, 0, 0, 0, 0, 0);
        repeat (12) @(negedge clk);
        chk_all("postrst_t12", 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("postrst_t13", 0, 1, 1, 24'h010101, 1, 0, 0);

        // randomized run against the reference model
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            chk("rnd_vsync", vs, ms.vs);
            chk("rnd_href", hr, ms.hr);
            chk("rnd_clken", ck, ms.ck);
            chk("rnd_data", dat, ms.d);
            chk("rnd_x", xp, ms.x);
            chk("rnd_y", yp, ms.y);
            chk("rnd_fcnt", fc, 16'(ms.fc));
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
